hazard_fwd_ctrl: RTL and testbench
==================================

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameter STALL_CNT_W, default 16, width of the saturating stall-cycle counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 d_rs, d_rt  input  5 each  D-stage source register numbers.
REQ-005 d_tuse_rs, d_tuse_rt  input  2 each  cycles until D-stage instruction consumes rs/rt (0..2; 3 = unused).
REQ-006 d_a3  input  5  destination register of D-stage instruction (0 = no write).
REQ-007 d_tnew  input  2  cycles after E-entry until result is available (0..2).
REQ-008 d_kind  input  2  result source: 0 NONE, 1 ALU, 2 MEM, 3 PC8.
REQ-009 fwd_rs_sel, fwd_rt_sel  output  3 each  select for the 5-way operand mux: 0 RF, 1 E-PC8, 2 M-ALU, 3 M-PC8, 4 W-data.
REQ-010 stall  output  1  freeze PC and D register, insert bubble into E.
REQ-011 stall_cnt  output  STALL_CNT_W  total stalled cycles since reset.

Function
REQ-012 Block SHALL hold three stage records E, M, W, each {a3[4:0], tnew[1:0], kind[1:0]}.
REQ-013 Each cycle without stall: E<=D inputs, M<=E, W<=M; tnew decremented by 1 on each transfer, saturating at 0.
REQ-014 Each cycle with stall: E<=all-zero bubble, M<=E, W<=M with the same decrement; D inputs not captured.
REQ-015 A record matches source r when a3==r and a3!=0; records with kind NONE never match.
REQ-016 Priority for matching SHALL be E over M over W (youngest producer wins).
REQ-017 stall SHALL assert combinationally when the highest-priority match for rs (or rt) has tnew > tuse of that operand; tuse 3 never stalls.
REQ-018 fwd_*_sel SHALL be combinational from current records: E match with tnew==0 and kind PC8 -> 1; M match tnew==0 kind ALU -> 2; M match tnew==0 kind PC8 -> 3; W match -> 4; no match -> 0.
REQ-019 If the highest-priority match is not yet ready, sel SHALL be 0 and stall SHALL be 1 (older ready matches are not used).
REQ-020 Register 0 SHALL always yield sel 0 and never stall.
REQ-021 stall_cnt SHALL increment by 1 on every rising edge where stall==1, saturating at all-ones.
REQ-022 rs and rt SHALL be evaluated independently; stall is the OR of both.

Reset
REQ-023 On reset assertion, immediately: E, M, W records all-zero, stall_cnt 0; hence stall 0, both sel 0.
REQ-024 Reset asserted mid-stall SHALL drop stall to 0 in the same cycle; first edge after deassertion captures D inputs normally.

Configuration
REQ-025 Macro HAZARD_FWD_EN: defined -> forwarding per REQ-018/019.
REQ-026 HAZARD_FWD_EN undefined -> both sel tied to 0; stall SHALL assert on any match in E, M or W regardless of tnew/tuse; stall_cnt unchanged in behaviour.

Structure
REQ-027 Shared package mips_pkg SHALL hold sel codes (SEL_RF..SEL_W), kind codes (KIND_NONE/ALU/MEM/PC8), TUSE_NONE=3 and the stage-record typedef.
REQ-028 One sub-module fwd_match SHALL be instantiated per operand (rs, rt): takes E/M/W records, register number and tuse; returns sel and stall_req.

Verification
REQ-029 addu $3 (tnew1,ALU) then addu using $3 (tuse1) next cycle -> stall 0 at first, M-stage sel 2 one cycle later, no stall cycle; stall_cnt 0.
REQ-030 lw $5 (tnew2,MEM) then beq using $5 (tuse0) -> stall 1 for 2 cycles, then sel 4; stall_cnt 2.
REQ-031 jal ($31, tnew0, PC8) then jr $31 (tuse0) -> sel 1 immediately, stall 0.
REQ-032 Writes to $0 in E/M/W with d_rs=0 -> sel 0, stall 0.
REQ-033 E and W both write $7, read $7 -> E selected; E not ready -> stall 1 despite ready W.
REQ-034 Reset pulse during lw-use stall -> stall 0 and stall_cnt 0 same cycle; HAZARD_FWD_EN undefined run of REQ-029 -> 3 stall cycles, sel 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline hazard / forwarding control slice.
// Holds the operand-mux select codes, result-kind codes, the "operand unused"
// tuse marker, the per-stage producer record and small record helpers.
package mips_pkg;

    typedef enum logic [2:0] {
        SEL_RF    = 3'd0,
        SEL_E_PC8 = 3'd1,
        SEL_M_ALU = 3'd2,
        SEL_M_PC8 = 3'd3,
        SEL_W     = 3'd4
    } sel_e;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_ALU  = 2'd1,
        KIND_MEM  = 2'd2,
        KIND_PC8  = 2'd3
    } kind_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        kind_e      kind;
    } stage_rec_t;

    // A record produces register rn when it writes a non-zero register with a real result.
    function automatic logic rec_match(input stage_rec_t r, input logic [4:0] rn);
        return (r.a3 == rn) && (r.a3 != 5'd0) && (r.kind != KIND_NONE);
    endfunction

    // Record as it appears one stage later: one cycle closer to its result.
    function automatic stage_rec_t rec_advance(input stage_rec_t r);
        stage_rec_t n;
        n = r;
        if (r.tnew != 2'd0) begin
            n.tnew = r.tnew - 2'd1;
        end
        return n;
    endfunction

    // Producer result arrives after the consumer needs it.
    function automatic logic too_late(input logic [1:0] tnew, input logic [1:0] tuse);
        return (tuse != TUSE_NONE) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand hazard resolution: finds the youngest E/M/W producer of one
// source register and returns the operand-mux select and a stall request.
// Forwarding is built only with HAZARD_FWD_EN defined; otherwise any pending
// producer of the register stalls and the operand always comes from the RF.
module fwd_match
    import mips_pkg::*;
(
    input  stage_rec_t  e_rec,
    input  stage_rec_t  m_rec,
    input  stage_rec_t  w_rec,
    input  logic [4:0]  rn,
    input  logic [1:0]  tuse,
    output logic [2:0]  sel,
    output logic        stall_req
);

    logic e_hit;
    logic m_hit;
    logic w_hit;

    assign e_hit = rec_match(e_rec, rn);
    assign m_hit = rec_match(m_rec, rn);
    assign w_hit = rec_match(w_rec, rn);

`ifdef HAZARD_FWD_EN
    // Youngest match decides alone: if it is late we stall, an older ready copy is ignored.
    always_comb begin
        sel       = SEL_RF;
        stall_req = 1'b0;
        if (e_hit) begin
            if (too_late(e_rec.tnew, tuse)) begin
                stall_req = 1'b1;
            end else if (e_rec.tnew == 2'd0 && e_rec.kind == KIND_PC8) begin
                sel = SEL_E_PC8;
            end
        end else if (m_hit) begin
            if (too_late(m_rec.tnew, tuse)) begin
                stall_req = 1'b1;
            end else if (m_rec.tnew == 2'd0) begin
                if (m_rec.kind == KIND_ALU) begin
                    sel = SEL_M_ALU;
                end else if (m_rec.kind == KIND_PC8) begin
                    sel = SEL_M_PC8;
                end
            end
        end else if (w_hit) begin
            if (too_late(w_rec.tnew, tuse)) begin
                stall_req = 1'b1;
            end else begin
                sel = SEL_W;
            end
        end
    end
`else
    // Without forwarding any in-flight producer of the register holds the consumer in D.
    always_comb begin
        sel       = SEL_RF;
        stall_req = e_hit | m_hit | w_hit;
    end

    logic unused_timing;
    assign unused_timing = ^{tuse, e_rec.tnew, m_rec.tnew, w_rec.tnew};
`endif

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS-style pipeline.
// Tracks the E/M/W producer records, resolves rs and rt independently through
// one fwd_match each, and counts stalled cycles (saturating).
// Optional forwarding is selected with the HAZARD_FWD_EN macro.
module hazard_fwd_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             d_rs,
    input  logic [4:0]             d_rt,
    input  logic [1:0]             d_tuse_rs,
    input  logic [1:0]             d_tuse_rt,
    input  logic [4:0]             d_a3,
    input  logic [1:0]             d_tnew,
    input  logic [1:0]             d_kind,
    output logic [2:0]             fwd_rs_sel,
    output logic [2:0]             fwd_rt_sel,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    stage_rec_t e_rec;
    stage_rec_t m_rec;
    stage_rec_t w_rec;
    stage_rec_t d_rec;

    logic stall_rs;
    logic stall_rt;

    assign d_rec = '{a3: d_a3, tnew: d_tnew, kind: kind_e'(d_kind)};

    fwd_match u_fwd_rs (
        .e_rec     (e_rec),
        .m_rec     (m_rec),
        .w_rec     (w_rec),
        .rn        (d_rs),
        .tuse      (d_tuse_rs),
        .sel       (fwd_rs_sel),
        .stall_req (stall_rs)
    );

    fwd_match u_fwd_rt (
        .e_rec     (e_rec),
        .m_rec     (m_rec),
        .w_rec     (w_rec),
        .rn        (d_rt),
        .tuse      (d_tuse_rt),
        .sel       (fwd_rt_sel),
        .stall_req (stall_rt)
    );

    assign stall = stall_rs | stall_rt;

    // Advance producer records; a stall injects a bubble into E and leaves D uncaptured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rec <= '0;
            m_rec <= '0;
            w_rec <= '0;
        end else begin
            e_rec <= stall ? stage_rec_t'('0) : d_rec;
            m_rec <= rec_advance(e_rec);
            w_rec <= rec_advance(m_rec);
        end
    end

    // Count stalled cycles, holding at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl. Expectations depend on whether the
// design is built with HAZARD_FWD_EN; the counter is narrowed to 2 bits so
// saturation is reachable.
module tb_hazard_fwd_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_kind;
    logic [2:0] fwd_rs_sel, fwd_rt_sel;
    logic       stall;
    logic [1:0] stall_cnt;

    typedef struct {
        string      tag;
        logic [2:0] rs_sel;
        logic [2:0] rt_sel;
        logic       stall;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #10 clk = ~clk;

    hazard_fwd_ctrl #(.STALL_CNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_tnew     (d_tnew),
        .d_kind     (d_kind),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic [4:0] a3, input logic [1:0] tnew, input logic [1:0] kind);
        d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
        d_a3 = a3; d_tnew = tnew; d_kind = kind;
    endtask

    task automatic cmp(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    endtask

    // Push expectation for the current stimulus, then settle and compare.
    task automatic step(input string tag, input logic [2:0] rs_sel, input logic [2:0] rt_sel,
                        input logic st, input logic [1:0] cnt);
        exp_t e;
        sb.push_back('{tag, rs_sel, rt_sel, st, cnt});
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, "rs_sel", {1'b0, fwd_rs_sel}, {1'b0, e.rs_sel});
            cmp(e.tag, "rt_sel", {1'b0, fwd_rt_sel}, {1'b0, e.rt_sel});
            cmp(e.tag, "stall",  {3'b0, stall},      {3'b0, e.stall});
            cmp(e.tag, "cnt",    {2'b0, stall_cnt},  {2'b0, e.cnt});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        step("rst", 3'd0, 3'd0, 1'b0, 2'd0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 3, 3, 0, 0, 0);
        #3;
        step("reset", 3'd0, 3'd0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        // addu $3 then consumer of $3 with tuse 1
        drive(1, 2, 3, 3, 3, 1, 1);
        step("A0", 3'd0, 3'd0, 1'b0, 2'd0);
        tick();
        drive(3, 4, 1, 1, 0, 0, 0);
        step("A1", 3'd0, 3'd0, !FWD, 2'd0);
        tick();
        step("A2", FWD ? 3'd2 : 3'd0, 3'd0, !FWD, FWD ? 2'd0 : 2'd1);
        tick();
        step("A3", FWD ? 3'd4 : 3'd0, 3'd0, !FWD, FWD ? 2'd0 : 2'd2);
        tick();
        step("A4", 3'd0, 3'd0, 1'b0, FWD ? 2'd0 : 2'd3);

        // lw $5 then beq using $5 with tuse 0
        do_reset();
        drive(1, 0, 3, 3, 5, 2, 2);
        step("B0", 3'd0, 3'd0, 1'b0, 2'd0);
        tick();
        drive(5, 0, 0, 0, 0, 0, 0);
        step("B1", 3'd0, 3'd0, 1'b1, 2'd0);
        tick();
        step("B2", 3'd0, 3'd0, 1'b1, 2'd1);
        tick();
        step("B3", FWD ? 3'd4 : 3'd0, 3'd0, !FWD, 2'd2);
        tick();
        step("B4", 3'd0, 3'd0, 1'b0, FWD ? 2'd2 : 2'd3);

        // second lw-use without reset: counter saturates
        drive(1, 0, 3, 3, 5, 2, 2);
        step("B5", 3'd0, 3'd0, 1'b0, FWD ? 2'd2 : 2'd3);
        tick();
        drive(5, 0, 0, 0, 0, 0, 0);
        step("B6", 3'd0, 3'd0, 1'b1, FWD ? 2'd2 : 2'd3);
        tick();
        tick();
        tick();
        step("B7", 3'd0, 3'd0, 1'b0, 2'd3);

        // reset pulse in the middle of a lw-use stall
        do_reset();
        drive(1, 0, 3, 3, 5, 2, 2);
        tick();
        drive(5, 0, 0, 0, 0, 0, 0);
        step("R1", 3'd0, 3'd0, 1'b1, 2'd0);
        tick();
        step("R2", 3'd0, 3'd0, 1'b1, 2'd1);
        do_reset();
        drive(1, 0, 3, 3, 5, 2, 2);
        tick();
        drive(5, 0, 0, 0, 0, 0, 0);
        step("R4", 3'd0, 3'd0, 1'b1, 2'd0);

        // jal $31 then jr $31
        do_reset();
        drive(0, 0, 3, 3, 31, 0, 3);
        step("C0", 3'd0, 3'd0, 1'b0, 2'd0);
        tick();
        drive(31, 0, 0, 0, 0, 0, 0);
        step("C1", FWD ? 3'd1 : 3'd0, 3'd0, !FWD, 2'd0);
        tick();
        step("C2", FWD ? 3'd3 : 3'd0, 3'd0, !FWD, FWD ? 2'd0 : 2'd1);

        // writes to $0 everywhere, read $0
        do_reset();
        drive(0, 0, 3, 3, 0, 2, 1);
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 2, 1);
        step("D0", 3'd0, 3'd0, 1'b0, 2'd0);

        // kind NONE producer never matches
        do_reset();
        drive(0, 0, 3, 3, 9, 2, 0);
        tick();
        drive(9, 9, 0, 0, 0, 0, 0);
        step("D1", 3'd0, 3'd0, 1'b0, 2'd0);

        // E and W both write $7: E ready (PC8) wins
        do_reset();
        drive(0, 0, 3, 3, 7, 0, 1);
        tick();
        drive(0, 0, 3, 3, 0, 0, 0);
        tick();
        drive(0, 0, 3, 3, 7, 0, 3);
        tick();
        drive(7, 7, 0, 0, 0, 0, 0);
        step("E0", FWD ? 3'd1 : 3'd0, FWD ? 3'd1 : 3'd0, !FWD, 2'd0);

        // E and W both write $7: E not ready stalls despite ready W
        do_reset();
        drive(0, 0, 3, 3, 7, 0, 1);
        tick();
        drive(0, 0, 3, 3, 0, 0, 0);
        tick();
        drive(0, 0, 3, 3, 7, 1, 1);
        tick();
        drive(7, 0, 0, 0, 0, 0, 0);
        step("E1", 3'd0, 3'd0, 1'b1, 2'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
